// File: rtl/vm_proj_reader.sv
// Purpose: drains the three VM projection memories filled by the router and
//          emits one VM-tagged word per handshake on a valid/ready stream.
// Latency: 2 cycles from read grant to out_valid; out_valid is driven from registers.
// Backpressure: a read is issued only if skid occupancy + in-flight reads < 2, so no word is dropped.
// Ports: clk/reset (sync, active-low); wr_en_1..3 snooped router strobes;
//        event_end starts the drain; read_add_1..3 / mem_out_1..3 memory read side;
//        out_data/out_vm/out_valid/out_ready output stream; done drain pulse; overflow sticky flag.
module vm_proj_reader #(
  parameter int DATA_W = 13,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_1,
  input  logic              wr_en_2,
  input  logic              wr_en_3,
  input  logic              event_end,
  output logic [ADDR_W-1:0] read_add_1,
  output logic [ADDR_W-1:0] read_add_2,
  output logic [ADDR_W-1:0] read_add_3,
  input  logic [DATA_W-1:0] mem_out_1,
  input  logic [DATA_W-1:0] mem_out_2,
  input  logic [DATA_W-1:0] mem_out_3,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_vm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, CLEAR = 2'd2} state_t;

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt  [3];
  logic [ADDR_W:0]   rptr [3];
  logic [2:0]        wr;
  logic [2:0]        nonempty;
  logic [1:0]        pri;        // index 0..2 of the VM with highest priority
  logic              gnt_vld;
  logic [1:0]        gnt_idx;
  logic [1:0]        cand [3];
  logic              can_issue;
  logic              rd_vld;     // a read issued last cycle; data on mem_out now
  logic [1:0]        rd_vm;
  logic [DATA_W-1:0] rd_dat;
  logic [1:0]        occ;
  logic [DATA_W-1:0] e0_dat, e1_dat;
  logic [1:0]        e0_vm, e1_vm;
  logic              pop;

  function automatic logic [1:0] next_idx(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign wr = {wr_en_3, wr_en_2, wr_en_1};

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      nonempty[k] = rptr[k] < cnt[k];
    end
  end

  assign read_add_1 = rptr[0][ADDR_W-1:0];
  assign read_add_2 = rptr[1][ADDR_W-1:0];
  assign read_add_3 = rptr[2][ADDR_W-1:0];

  // Round-robin search order starting at the priority pointer.
  assign cand[0] = pri;
  assign cand[1] = next_idx(pri);
  assign cand[2] = next_idx(next_idx(pri));

  assign can_issue = (state != CLEAR) && (({1'b0, occ} + {2'b00, rd_vld}) < 3'd2);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    if (can_issue) begin
      for (int i = 0; i < 3; i++) begin
        if (!gnt_vld && nonempty[cand[i]]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand[i];
        end
      end
    end
  end

  always_comb begin
    case (rd_vm)
      2'd1:    rd_dat = mem_out_1;
      2'd2:    rd_dat = mem_out_2;
      2'd3:    rd_dat = mem_out_3;
      default: rd_dat = '0;
    endcase
  end

  // Skid buffer head is e0; unused entries are kept zero so out_vm reads 0 when empty.
  assign out_valid = (occ != 2'd0);
  assign out_data  = e0_dat;
  assign out_vm    = e0_vm;
  assign pop       = out_valid & out_ready;
  assign done      = (state == CLEAR);

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (event_end) state_nxt = DRAIN;
      DRAIN:   if ((nonempty == 3'b000) && !rd_vld &&
                   ((occ == 2'd0) || ((occ == 2'd1) && pop)))
                 state_nxt = CLEAR;
      CLEAR:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= RUN;
      for (int k = 0; k < 3; k++) begin
        cnt[k]  <= '0;
        rptr[k] <= '0;
      end
      pri      <= 2'd0;
      rd_vld   <= 1'b0;
      rd_vm    <= 2'd0;
      occ      <= 2'd0;
      e0_dat   <= '0;
      e0_vm    <= 2'd0;
      e1_dat   <= '0;
      e1_vm    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      state  <= state_nxt;
      rd_vld <= gnt_vld;
      rd_vm  <= gnt_vld ? gnt_idx + 2'd1 : 2'd0;

      for (int k = 0; k < 3; k++) begin
        if (state == CLEAR) begin
          cnt[k]  <= '0;
          rptr[k] <= '0;
        end else begin
          // Writes are only counted while the event is still being filled.
          if (wr[k] && (state == RUN)) begin
            if (cnt[k] == FULL) overflow <= 1'b1;
            else                cnt[k]   <= cnt[k] + 1'b1;
          end
          if (gnt_vld && (gnt_idx == 2'(k))) rptr[k] <= rptr[k] + 1'b1;
        end
      end

      if (state == CLEAR) pri <= 2'd0;
      else if (gnt_vld)   pri <= next_idx(gnt_idx);

      case ({rd_vld, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            e0_dat <= rd_dat;
            e0_vm  <= rd_vm;
          end else begin
            e1_dat <= rd_dat;
            e1_vm  <= rd_vm;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          e0_dat <= e1_dat;
          e0_vm  <= e1_vm;
          e1_dat <= '0;
          e1_vm  <= 2'd0;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            e0_dat <= rd_dat;
            e0_vm  <= rd_vm;
          end else begin
            e0_dat <= e1_dat;
            e0_vm  <= e1_vm;
            e1_dat <= rd_dat;
            e1_vm  <= rd_vm;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vm_proj_reader.sv
module tb_vm_proj_reader;
  localparam int DW = 13;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset, wr_en_1, wr_en_2, wr_en_3, event_end, out_ready;
  logic [AW-1:0] read_add_1, read_add_2, read_add_3;
  logic [DW-1:0] mem_out_1, mem_out_2, mem_out_3, out_data;
  logic [1:0]    out_vm;
  logic          out_valid, done, overflow;

  always #5 clk = ~clk;

  vm_proj_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .wr_en_1(wr_en_1), .wr_en_2(wr_en_2), .wr_en_3(wr_en_3),
    .event_end(event_end),
    .read_add_1(read_add_1), .read_add_2(read_add_2), .read_add_3(read_add_3),
    .mem_out_1(mem_out_1), .mem_out_2(mem_out_2), .mem_out_3(mem_out_3),
    .out_data(out_data), .out_vm(out_vm), .out_valid(out_valid),
    .out_ready(out_ready), .done(done), .overflow(overflow)
  );

  // VM memories: synchronous read, data one cycle after address.
  logic [DW-1:0] mem1 [0:511];
  logic [DW-1:0] mem2 [0:511];
  logic [DW-1:0] mem3 [0:511];
  always @(posedge clk) begin
    mem_out_1 <= mem1[read_add_1];
    mem_out_2 <= mem2[read_add_2];
    mem_out_3 <= mem3[read_add_3];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] base(input int k);
    case (k)
      1:       return 13'h0B1;
      2:       return 13'h0A1;
      default: return 13'h0C1;
    endcase
  endfunction

  // Ready generator: either held level or the 1,0,0,1,0,0... pattern.
  bit ready_mode = 0;
  bit ready_hold = 1;
  int rc = 0;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = ready_mode ? (rc % 3 == 0) : ready_hold;
      rc++;
    end
  end

  // Output monitor.
  logic [15:0]   got [$];
  int            first_val_cyc = -1;
  int            last_acc_cyc = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_dat;
  logic [1:0]    prev_vm;

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_dat));
        chk("stall_vm", 32'(out_vm), 32'(prev_vm));
      end
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_data;
      prev_vm    = out_vm;
      if (out_valid && out_ready) begin
        got.push_back({1'b0, out_vm, out_data});
        last_acc_cyc = cyc;
      end
      if (out_valid && first_val_cyc < 0) first_val_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  typedef struct {
    int          n1, n2, n3;  // wr_en pulses per VM, issued from the same start cycle
    bit          stall;       // 1: out_ready follows 1,0,0 pattern
    int          len;         // expected number of output words
    logic [11:0] vmseq;       // expected out_vm sequence, word i at [2i+:2]
    logic [1:0]  fixed_vm;    // nonzero: every word expected from this VM
    bit          ovf;         // overflow expected
  } vec_t;

  function automatic vec_t mk(input int a, input int b, input int c, input bit st, input int len,
                              input logic [11:0] seq, input logic [1:0] fv, input bit ov);
    vec_t v;
    v.n1 = a; v.n2 = b; v.n3 = c; v.stall = st; v.len = len;
    v.vmseq = seq; v.fixed_vm = fv; v.ovf = ov;
    return v;
  endfunction

  task automatic run_load(input vec_t v);
    int w1, w2, w3, maxn, first_wr_cyc, nchk;
    int idx [4];
    logic [1:0] evm;
    w1 = 0; w2 = 0; w3 = 0; first_wr_cyc = 0;
    idx[0] = 0; idx[1] = 0; idx[2] = 0; idx[3] = 0;
    maxn = v.n1;
    if (v.n2 > maxn) maxn = v.n2;
    if (v.n3 > maxn) maxn = v.n3;
    got.delete();
    first_val_cyc = -1;
    done_cnt = 0;
    ready_mode = v.stall;
    ready_hold = 1;
    for (int c = 0; c < maxn; c++) begin
      @(posedge clk); #1;
      if (v.ovf && c == 512) chk("ovf_before_513", 32'(overflow), 32'd0);
      wr_en_1 = (c < v.n1);
      wr_en_2 = (c < v.n2);
      wr_en_3 = (c < v.n3);
      if (wr_en_1 && w1 < 512) begin mem1[w1] = base(1) + w1[DW-1:0]; w1++; end
      if (wr_en_2 && w2 < 512) begin mem2[w2] = base(2) + w2[DW-1:0]; w2++; end
      if (wr_en_3 && w3 < 512) begin mem3[w3] = base(3) + w3[DW-1:0]; w3++; end
      if (c == 0) first_wr_cyc = cyc;
    end
    @(posedge clk); #1;
    if (v.ovf) chk("ovf_after_513", 32'(overflow), 32'd1);
    wr_en_1 = 0; wr_en_2 = 0; wr_en_3 = 0;
    event_end = 1;
    @(posedge clk); #1;
    event_end = 0;
    for (int t = 0; t < 4000 && done_cnt == 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("word_count", 32'(got.size()), 32'(v.len));
    nchk = (got.size() < v.len) ? got.size() : v.len;
    for (int i = 0; i < nchk; i++) begin
      evm = (v.fixed_vm != 2'd0) ? v.fixed_vm : v.vmseq[2*i +: 2];
      chk("word_vm", 32'(got[i][14:13]), 32'(evm));
      chk("word_data", 32'(got[i][12:0]), 32'(base(int'(evm)) + idx[evm][DW-1:0]));
      idx[evm]++;
    end
    chk("first_latency", 32'(first_val_cyc - first_wr_cyc), 32'd3);
    chk("done_after_last", 32'(done_cyc - last_acc_cyc), 32'd1);
    chk("read_add_clear", {5'd0, read_add_1, read_add_2, read_add_3}, 32'd0);
    chk("idle_after_done", {30'd0, out_valid, out_vm != 2'd0}, 32'd0);
    chk("overflow_flag", 32'(overflow), 32'(v.ovf));
  endtask

  vec_t vecs [5];
  int   ee_cyc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(0, 3, 0, 0, 3, 12'b00_00_00_10_10_10, 2'd0, 0);
    vecs[1] = mk(2, 2, 2, 0, 6, 12'b11_10_01_11_10_01, 2'd0, 0);
    vecs[2] = mk(2, 2, 2, 1, 6, 12'b11_10_01_11_10_01, 2'd0, 0);
    vecs[3] = mk(1, 0, 2, 0, 3, 12'b00_00_00_11_11_01, 2'd0, 0);
    vecs[4] = mk(513, 0, 0, 0, 512, 12'd0, 2'd1, 1);

    for (int i = 0; i < 512; i++) begin
      mem1[i] = '0; mem2[i] = '0; mem3[i] = '0;
    end
    reset = 0; wr_en_1 = 0; wr_en_2 = 0; wr_en_3 = 0; event_end = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_vm", 32'(out_vm), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("rst_idle", {2'd0, out_valid, done, overflow, read_add_1, read_add_2, read_add_3}, 32'd0);
      @(negedge clk);
    end

    for (int i = 0; i < 5; i++) run_load(vecs[i]);

    // Reset in DRAIN with the skid buffer full.
    ready_mode = 0;
    ready_hold = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      wr_en_3 = 1;
      mem3[c] = base(3) + 13'(c);
      @(posedge clk); #1;
    end
    wr_en_3 = 0;
    event_end = 1;
    @(posedge clk); #1;
    event_end = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    reset = 0;
    got.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    chk("post_reset_valid", 32'(out_valid), 32'd0);
    chk("post_reset_addr", 32'(read_add_3), 32'd0);
    chk("post_reset_ovf", 32'(overflow), 32'd0);
    ready_hold = 1;
    repeat (10) @(negedge clk);
    chk("post_reset_no_done", 32'(done_cnt), 32'd0);
    chk("post_reset_no_words", 32'(got.size()), 32'd0);
    chk("post_reset_idle", 32'(out_valid), 32'd0);

    // event_end with all VMs empty.
    @(posedge clk); #1;
    event_end = 1;
    ee_cyc = cyc;
    done_cnt = 0;
    @(posedge clk); #1;
    event_end = 0;
    repeat (5) @(negedge clk);
    chk("empty_done_pulses", 32'(done_cnt), 32'd1);
    chk("empty_done_delay", 32'(done_cyc - ee_cyc), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vm_proj_reader.md
Name: vm_proj_reader

Overview:
- Read-side consumer of the three VM projection memories filled by the projection router.
- Snoops the router's three write enables to keep per-VM fill counts.
- Generates read addresses into the three memories, round-robin arbitrates among non-empty VMs, and emits one tagged projection per cycle on a valid/ready stream.
- Signals when an event's projections are fully drained, then clears for the next event.

Parameters:
- DATA_W, 13, VM projection word width
- ADDR_W, 9, VM memory address width; depth = 2^ADDR_W

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- wr_en_1  input  1  router write strobe into VM memory 1 (snooped)
- wr_en_2  input  1  router write strobe into VM memory 2 (snooped)
- wr_en_3  input  1  router write strobe into VM memory 3 (snooped)
- event_end  input  1  one-cycle pulse: router finished writing current event
- read_add_1  output  ADDR_W  read address, VM memory 1
- read_add_2  output  ADDR_W  read address, VM memory 2
- read_add_3  output  ADDR_W  read address, VM memory 3
- mem_out_1  input  DATA_W  VM memory 1 read data, valid 1 cycle after address
- mem_out_2  input  DATA_W  VM memory 2 read data, valid 1 cycle after address
- mem_out_3  input  DATA_W  VM memory 3 read data, valid 1 cycle after address
- out_data  output  DATA_W  projection word
- out_vm  output  2  source VM tag: 1, 2 or 3 (0 when invalid)
- out_valid  output  1  out_data/out_vm valid
- out_ready  input  1  downstream accepts when out_valid & out_ready
- done  output  1  one-cycle pulse: event fully drained
- overflow  output  1  sticky: a write was snooped into a full VM

Behaviour:
- Reset (reset==0 at clk edge):
  - all counts and read pointers = 0, read_add_* = 0
  - out_valid = 0, out_data = 0, out_vm = 0, done = 0, overflow = 0
  - skid buffer empty, state RUN, round-robin priority = VM1
  - Reset mid-operation discards in-flight reads and buffered words.
- Fill counts:
  - cnt_k is ADDR_W+1 bits.
  - wr_en_k increments cnt_k, saturating at 2^ADDR_W.
  - A wr_en_k while cnt_k == 2^ADDR_W is dropped and sets overflow; overflow clears only on reset.
- VM k is non-empty when rptr_k < cnt_k. rptr_k is ADDR_W+1 bits; read_add_k = rptr_k[ADDR_W-1:0].
- Issue:
  - At most one read per cycle, and only when (skid occupancy + in-flight reads) < 2.
  - Grant goes to the first non-empty VM in priority order starting at the priority pointer.
  - Granted rptr_k increments; priority moves to k+1 (3 wraps to 1).
  - A write and a read to the same VM in the same cycle are both applied.
  - A read may be granted the cycle after the corresponding wr_en (memory write latency 1).
- Data path:
  - The granted VM index is registered with the read.
  - Next cycle, mem_out_k is captured into a 2-entry FIFO (skid buffer) with tag k.
  - The FIFO head drives out_data/out_vm/out_valid from registers.
  - Minimum latency from grant to out_valid is 2 cycles.
  - out_data and out_vm hold stable while out_valid & !out_ready.
  - Words are never lost or duplicated under backpressure.
  - Output order equals grant order.
- State machine:
  - RUN: normal operation. On event_end go to DRAIN. A wr_en in the same cycle as event_end is counted.
  - DRAIN:
    - wr_en_* ignored (not counted).
    - Issue continues.
    - When all VMs are empty, no read is in flight, the FIFO is empty, and out_valid is 0 (or the last word is accepted this cycle), go to CLEAR.
  - CLEAR (1 cycle):
    - done = 1.
    - cnt_*, rptr_*, read_add_* = 0; priority = VM1.
    - Next state RUN.
    - wr_en/event_end in CLEAR are ignored.
  - event_end with all counts 0: DRAIN then CLEAR, so done occurs 2 cycles after event_end.
  - event_end while in DRAIN/CLEAR: ignored.

Test Plan:
- Reset low 2 cycles, then high, no activity -> out_valid=0, read_add_*=0, done=0, overflow=0 indefinitely.
- 3 wr_en_2 pulses (mem2 words 0x0A1, 0x0A2, 0x0A3), out_ready=1, then event_end -> out stream 0x0A1, 0x0A2, 0x0A3 with out_vm=2, first out_valid 3 cycles after first wr_en; done one cycle after last word accepted.
- 2 words in each VM (all full counts before event_end), out_ready=1 -> out_vm order 1, 2, 3, 1, 2, 3; then done pulse; read_add_* back to 0.
- Same load with out_ready toggling 1,0,0,1,... -> identical 6-word sequence, outputs stable during stalls, no drops or duplicates, FIFO never exceeds 2.
- 513 wr_en_1 pulses -> cnt_1=512, overflow=1 after pulse 513; drain yields exactly 512 words, addresses 0..511; overflow stays 1 after done.
- event_end with empty VMs -> done exactly 2 cycles later. Separately, reset asserted during DRAIN with 2 words buffered -> out_valid=0 next cycle, counts 0, no done pulse.
